id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage between instruction fetch and execute in the RISC-V core.
- Accepts one instruction per cycle from fetch over a valid/ready handshake, splits out rs1/rs2/rd and drives the register file read addresses.
- Generates the immediate and bypasses same-cycle writeback data.
- Latches everything into the ID/EX pipeline register. Detects load-use hazards and inserts one bubble.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- id_ready  out  1  decode accepts if_instr this cycle
- AddrA  out  5  register file read address A = if_instr[19:15]
- AddrB  out  5  register file read address B = if_instr[24:20]
- DataA  in  32  register file read data A (combinational read)
- DataB  in  32  register file read data B
- wb_RegWEn  in  1  writeback write enable (same signal driving the register file)
- wb_AddrD  in  5  writeback destination
- wb_DataD  in  32  writeback data
- ex_ready  in  1  execute accepts the ID/EX contents
- flush  in  1  branch/jump redirect: kill decode and ID/EX
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc  out  32  registered PC
- ex_instr  out  32  registered instruction
- ex_rs1_data  out  32  registered operand 1
- ex_rs2_data  out  32  registered operand 2
- ex_imm  out  32  registered sign-extended immediate
- ex_rd  out  5  registered destination
- ex_RegWEn  out  1  instruction writes rd (rd != 0)
- ex_is_load  out  1  opcode 0000011
- ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs are 0. id_ready follows its combinational equation.
- Decode is combinational on if_instr. Opcodes:
  - LOAD, OP-IMM, JALR: I-type immediate.
  - STORE: S-type immediate.
  - BRANCH: B-type immediate.
  - LUI, AUIPC: U-type immediate.
  - JAL: J-type immediate.
  - OP: immediate 0.
  - Any other opcode: ex_illegal=1, RegWEn=0.
- Immediates are sign-extended to XLEN. B and J immediates have bit0 = 0.
- rs usage:
  - uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
- RegWEn = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, provided rd != 0.
- Operand selection, per operand:
  - Address 0 gives 0.
  - Else, if wb_RegWEn && wb_AddrD == address, use wb_DataD (write-through bypass).
  - Else use DataA/DataB.
- Hazard: ex_valid && ex_is_load && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
- id_ready = flush || ((!ex_valid || ex_ready) && !hazard).
- Next-state priority, evaluated each edge:
  1. flush=1: ex_valid <= 0, ex_RegWEn <= 0, ex_is_load <= 0. The fetched instruction is dropped even if if_valid=1.
  2. ex_valid && !ex_ready: hold all ex_* registers.
  3. hazard (execute draining): bubble. ex_valid <= 0, ex_RegWEn <= 0, ex_is_load <= 0, other fields hold.
  4. if_valid: load all ex_* from decode, ex_valid <= 1.
  5. Otherwise: ex_valid <= 0, ex_RegWEn <= 0, ex_is_load <= 0.
- Latency: one cycle from accepted if_instr to ex_valid.
- A load-use pair costs exactly one bubble. The hazard clears once the load leaves ID/EX.
- Reset asserted mid-stall or mid-hold clears ID/EX immediately. No partial transfer occurs.
- AddrA/AddrB are driven from if_instr regardless of if_valid.

Test Plan:
- Reset: hold rst=0 with if_valid=1 → ex_valid=0, ex_rd=0, ex_RegWEn=0 throughout. First edge after release latches the instruction.
- Immediate: addi x5,x1,-1 (0xFFF08293) → ex_imm=0xFFFFFFFF, ex_rd=5, ex_RegWEn=1. beq x1,x2,-4 (0xFE208EE3) → ex_imm=0xFFFFFFFC, ex_RegWEn=0.
- Bypass: DataA=0x11, wb_RegWEn=1, wb_AddrD=1, wb_DataD=0x1244, instr add x3,x1,x2 → ex_rs1_data=0x1244. Same with wb_AddrD=0 → 0x11. rs1=x0 → 0.
- Load-use: lw x7,0(x1) then add x8,x7,x2, ex_ready=1:
  - id_ready=0 for one cycle.
  - One cycle with ex_valid=0.
  - The add enters next. No stall if the add reads x6 instead.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable, id_ready=0. Resumes with no loss or duplication.
- Flush: flush=1 while ID/EX holds an instruction and if_valid=1 → next cycle ex_valid=0, id_ready=1 during flush. Illegal opcode 0x0000007F → ex_illegal=1, ex_RegWEn=0.

Source files
------------

// File: rtl/id_stage_if.sv
// Fetch-to-decode handshake: fetch presents an instruction and its PC;
// decode answers with id_ready in the same cycle.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (output if_valid, if_instr, if_pc, input  id_ready);
    modport slave  (input  if_valid, if_instr, if_pc, output id_ready);
endinterface

// File: rtl/id_stage.sv
// RV32 decode stage: field split, immediate generation, write-through operand
// bypass, load-use bubble insertion and the ID/EX pipeline register.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    id_stage_if.slave       fetch,
    output logic [4:0]      AddrA,
    output logic [4:0]      AddrB,
    input  logic [XLEN-1:0] DataA,
    input  logic [XLEN-1:0] DataB,
    input  logic            wb_RegWEn,
    input  logic [4:0]      wb_AddrD,
    input  logic [XLEN-1:0] wb_DataD,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_RegWEn,
    output logic            ex_is_load,
    output logic            ex_illegal
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    function automatic logic signed [XLEN-1:0] immGen(input logic [31:0] ins);
        logic signed [31:0] imm32;
        imm32 = '0;
        case (ins[6:0])
            OpLoad, OpImm, OpJalr: imm32 = {{20{ins[31]}}, ins[31:20]};
            OpStore:               imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OpBranch:              imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OpLui, OpAuipc:        imm32 = {ins[31:12], 12'b0};
            OpJal:                 imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:               imm32 = '0;
        endcase
        return XLEN'(imm32);
    endfunction

    // x0 reads as zero; a same-cycle writeback to the read address wins over the file
    function automatic logic [XLEN-1:0] selOperand(input logic [4:0]      addr,
                                                   input logic [XLEN-1:0] rfData,
                                                   input logic            wbEn,
                                                   input logic [4:0]      wbAddr,
                                                   input logic [XLEN-1:0] wbData);
        if (addr == 5'd0)
            return '0;
        else if (wbEn && (wbAddr == addr))
            return wbData;
        else
            return rfData;
    endfunction

    logic [6:0]             opcode;
    logic [4:0]             rd;
    logic                   usesRs1;
    logic                   usesRs2;
    logic                   writesRd;
    logic                   isLoad;
    logic                   illegal;
    logic                   hazard;
    logic                   loadEn;
    logic signed [XLEN-1:0] immDec;
    logic [XLEN-1:0]        rs1Data;
    logic [XLEN-1:0]        rs2Data;

    assign opcode = fetch.if_instr[6:0];
    assign rd     = fetch.if_instr[11:7];
    assign AddrA  = fetch.if_instr[19:15];
    assign AddrB  = fetch.if_instr[24:20];

    always_comb begin
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        writesRd = 1'b0;
        isLoad   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OpReg:    begin usesRs1 = 1'b1; usesRs2 = 1'b1; writesRd = 1'b1; end
            OpImm:    begin usesRs1 = 1'b1; writesRd = 1'b1; end
            OpLoad:   begin usesRs1 = 1'b1; writesRd = 1'b1; isLoad = 1'b1; end
            OpStore:  begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
            OpBranch: begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
            OpJalr:   begin usesRs1 = 1'b1; writesRd = 1'b1; end
            OpLui, OpAuipc, OpJal: writesRd = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end

    assign immDec  = immGen(fetch.if_instr);
    assign rs1Data = selOperand(AddrA, DataA, wb_RegWEn, wb_AddrD, wb_DataD);
    assign rs2Data = selOperand(AddrB, DataB, wb_RegWEn, wb_AddrD, wb_DataD);

    assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((usesRs1 && (ex_rd == AddrA)) || (usesRs2 && (ex_rd == AddrB)));

    assign fetch.id_ready = flush || ((!ex_valid || ex_ready) && !hazard);
    assign loadEn         = fetch.if_valid && !hazard;

    // ID/EX register: flush beats hold; a bubble or idle cycle clears only the control flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_instr    <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_RegWEn   <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_RegWEn  <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (!ex_valid || ex_ready) begin
            if (loadEn) begin
                ex_valid    <= 1'b1;
                ex_pc       <= fetch.if_pc;
                ex_instr    <= fetch.if_instr;
                ex_rs1_data <= rs1Data;
                ex_rs2_data <= rs2Data;
                ex_imm      <= immDec;
                ex_rd       <= rd;
                ex_RegWEn   <= writesRd && (rd != 5'd0);
                ex_is_load  <= isLoad;
                ex_illegal  <= illegal;
            end else begin
                ex_valid   <= 1'b0;
                ex_RegWEn  <= 1'b0;
                ex_is_load <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, immediates, bypass, load-use bubble,
// backpressure hold, flush, illegal opcode and asynchronous reset during a hold.
module tb_id_stage;
    logic        clk;
    logic        rst;
    logic [4:0]  AddrA, AddrB;
    logic [31:0] DataA, DataB;
    logic        wb_RegWEn;
    logic [4:0]  wb_AddrD;
    logic [31:0] wb_DataD;
    logic        ex_ready, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_RegWEn, ex_is_load, ex_illegal;

    int total = 0;
    int bad   = 0;

    id_stage_if #(.XLEN(32)) fetchIf ();

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .fetch(fetchIf),
        .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
        .wb_RegWEn(wb_RegWEn), .wb_AddrD(wb_AddrD), .wb_DataD(wb_DataD),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_is_load(ex_is_load),
        .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        fetchIf.if_valid = valid;
        fetchIf.if_instr = instr;
        fetchIf.if_pc    = pc;
    endtask

    initial begin
        rst       = 1'b0;
        DataA     = 32'h0000_000A;
        DataB     = 32'h0000_000B;
        wb_RegWEn = 1'b0;
        wb_AddrD  = 5'd0;
        wb_DataD  = 32'h0;
        ex_ready  = 1'b1;
        flush     = 1'b0;
        drive(1'b1, 32'hFFF08293, 32'h100);   // addi x5,x1,-1

        // held in reset with a valid instruction waiting
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", ex_valid, 0);
            check("rst_rd", ex_rd, 0);
            check("rst_regwen", ex_RegWEn, 0);
        end
        check("rst_idready", fetchIf.id_ready, 1);
        rst = 1'b1;
        #1 check("rst_release_noedge", ex_valid, 0);

        step();
        check("addi_valid", ex_valid, 1);
        check("addi_imm", ex_imm, 32'hFFFF_FFFF);
        check("addi_rd", ex_rd, 5);
        check("addi_regwen", ex_RegWEn, 1);
        check("addi_pc", ex_pc, 32'h100);
        check("addi_rs1", ex_rs1_data, 32'hA);

        drive(1'b1, 32'hFE208EE3, 32'h104);   // beq x1,x2,-4
        step();
        check("beq_imm", ex_imm, 32'hFFFF_FFFC);
        check("beq_regwen", ex_RegWEn, 0);
        check("beq_rs2", ex_rs2_data, 32'hB);

        DataA = 32'h11; wb_RegWEn = 1'b1; wb_AddrD = 5'd1; wb_DataD = 32'h1244;
        drive(1'b1, 32'h002081B3, 32'h108);   // add x3,x1,x2
        #1;
        check("addrA", AddrA, 1);
        check("addrB", AddrB, 2);
        step();
        check("byp_rs1", ex_rs1_data, 32'h1244);
        check("byp_rs2_nomatch", ex_rs2_data, 32'hB);
        check("add_imm", ex_imm, 0);
        check("add_rd", ex_rd, 3);

        wb_AddrD = 5'd0;
        step();
        check("byp_x0_rs1", ex_rs1_data, 32'h11);

        wb_AddrD = 5'd2; wb_DataD = 32'h5555;
        step();
        check("byp_rs2", ex_rs2_data, 32'h5555);
        check("byp_rs2_rs1", ex_rs1_data, 32'h11);

        wb_AddrD = 5'd0; wb_DataD = 32'h1244;
        drive(1'b1, 32'h002001B3, 32'h10C);   // add x3,x0,x2
        step();
        check("rs1_x0", ex_rs1_data, 0);
        wb_RegWEn = 1'b0;

        drive(1'b1, 32'h00000013, 32'h110);   // addi x0,x0,0
        step();
        check("rd0_valid", ex_valid, 1);
        check("rd0_regwen", ex_RegWEn, 0);

        // load-use on rs1
        drive(1'b1, 32'h0000A383, 32'h200);   // lw x7,0(x1)
        step();
        check("lw_isload", ex_is_load, 1);
        check("lw_rd", ex_rd, 7);
        drive(1'b1, 32'h00238433, 32'h204);   // add x8,x7,x2
        #1 check("lu_stall", fetchIf.id_ready, 0);
        step();
        check("lu_bubble", ex_valid, 0);
        check("lu_bubble_load", ex_is_load, 0);
        check("lu_ready_again", fetchIf.id_ready, 1);
        step();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_instr", ex_instr, 32'h00238433);
        check("lu_add_pc", ex_pc, 32'h204);

        // independent consumer: no stall
        drive(1'b1, 32'h0000A383, 32'h300);
        step();
        drive(1'b1, 32'h00230433, 32'h304);   // add x8,x6,x2
        #1 check("nolu_ready", fetchIf.id_ready, 1);
        step();
        check("nolu_valid", ex_valid, 1);
        check("nolu_instr", ex_instr, 32'h00230433);

        // load-use on rs2
        drive(1'b1, 32'h0000A103, 32'h310);   // lw x2,0(x1)
        step();
        drive(1'b1, 32'h002081B3, 32'h314);   // add x3,x1,x2
        #1 check("lu2_stall", fetchIf.id_ready, 0);
        step();
        check("lu2_bubble", ex_valid, 0);
        step();
        check("lu2_add_pc", ex_pc, 32'h314);

        // backpressure
        drive(1'b1, 32'h12345537, 32'h400);   // lui x10,0x12345
        step();
        check("lui_imm", ex_imm, 32'h1234_5000);
        check("lui_rd", ex_rd, 10);
        ex_ready = 1'b0;
        drive(1'b1, 32'h008000EF, 32'h404);   // jal x1,8
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_idready", fetchIf.id_ready, 0);
            step();
            check("bp_valid", ex_valid, 1);
            check("bp_instr", ex_instr, 32'h12345537);
            check("bp_imm", ex_imm, 32'h1234_5000);
        end
        ex_ready = 1'b1;
        #1 check("bp_resume_ready", fetchIf.id_ready, 1);
        step();
        check("jal_pc", ex_pc, 32'h404);
        check("jal_imm", ex_imm, 32'h8);
        check("jal_rd", ex_rd, 1);
        check("jal_regwen", ex_RegWEn, 1);
        drive(1'b0, 32'h008000EF, 32'h404);
        step();
        check("no_dup", ex_valid, 0);

        // flush beats hold and drops the fetched instruction
        drive(1'b1, 32'hFFF08293, 32'h500);
        step();
        check("pre_flush_valid", ex_valid, 1);
        ex_ready = 1'b0; flush = 1'b1;
        drive(1'b1, 32'hFE20AE23, 32'h504);
        #1 check("flush_ready", fetchIf.id_ready, 1);
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_regwen", ex_RegWEn, 0);
        flush = 1'b0; ex_ready = 1'b1;

        drive(1'b1, 32'hFE20AE23, 32'h600);   // sw x2,-4(x1)
        step();
        check("sw_imm", ex_imm, 32'hFFFF_FFFC);
        check("sw_regwen", ex_RegWEn, 0);
        check("sw_rs2", ex_rs2_data, 32'hB);

        drive(1'b1, 32'h0000007F, 32'h604);
        step();
        check("ill_flag", ex_illegal, 1);
        check("ill_regwen", ex_RegWEn, 0);
        check("ill_valid", ex_valid, 1);

        // asynchronous reset during a hold
        ex_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("hold_valid", ex_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", ex_valid, 0);
        check("async_rst_illegal", ex_illegal, 0);
        check("async_rst_pc", ex_pc, 0);
        rst = 1'b1; ex_ready = 1'b1;
        step();
        check("post_rst_idle", ex_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
